// File: rtl/sm3_expnd_core.sv
// SM3 message expansion: loads one 512-bit block and streams 64 rounds
// of Wj, W'j and rotated Tj from a 16-word sliding window.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   blk_vld_i/blk_rdy_o   block handshake, blk_data_i = W0..W15 (W0 in MSBs)
//   rnd_vld_o/rnd_rdy_i   round handshake
//   rnd_idx_o, rnd_last_o round index j and j==63 flag
//   cmprss_round_sm_16_o  j < 16
//   tj_o, wj_o, wjj_o     Tj<<<(j mod 32), Wj, Wj^Wj+4
module sm3_expnd_core #(
  parameter bit BYTE_SWAP = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         blk_vld_i,
  output logic         blk_rdy_o,
  input  logic [511:0] blk_data_i,
  output logic         rnd_vld_o,
  input  logic         rnd_rdy_i,
  output logic [5:0]   rnd_idx_o,
  output logic         rnd_last_o,
  output logic         cmprss_round_sm_16_o,
  output logic [31:0]  tj_o,
  output logic [31:0]  wj_o,
  output logic [31:0]  wjj_o
);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  localparam logic [31:0] T_LO = 32'h79cc4519;
  localparam logic [31:0] T_HI = 32'h7a879d8a;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] win_q [16];
  logic [5:0]  j_q;
  logic        blk_hs;
  logic        rnd_hs;
  logic        j_end;
  logic [31:0] mix;
  logic [31:0] p1_mix;
  logic [31:0] w_new;
  logic [31:0] t_base;

  function automatic logic [31:0] rotl(
    input logic [31:0] x,
    input logic [4:0]  n
  );
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [31:0] load_word(
    input logic [511:0] d,
    input int           i
  );
    logic [31:0] w;
    w = d[511-32*i -: 32];
    return BYTE_SWAP ? bswap(w) : w;
  endfunction

  assign blk_hs = blk_vld_i && (state_q == IDLE);
  assign rnd_hs = rnd_vld_o && rnd_rdy_i;
  assign j_end  = (j_q == 6'd63);

  // Window holds Wj..Wj+15, so the new word is Wj+16.
  assign mix    = win_q[0] ^ win_q[7] ^ rotl(win_q[13], 5'd15);
  assign p1_mix = mix ^ rotl(mix, 5'd15) ^ rotl(mix, 5'd23);
  assign w_new  = p1_mix ^ rotl(win_q[3], 5'd7) ^ win_q[10];

  always_comb begin
    state_d   = state_q;
    blk_rdy_o = 1'b0;
    rnd_vld_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        blk_rdy_o = 1'b1;
        if (blk_vld_i) state_d = RUN;
      end
      RUN: begin
        rnd_vld_o = 1'b1;
        if (rnd_rdy_i && j_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      j_q     <= '0;
      for (int i = 0; i < 16; i++) win_q[i] <= '0;
    end else begin
      state_q <= state_d;
      if (blk_hs) begin
        j_q <= '0;
        for (int i = 0; i < 16; i++) win_q[i] <= load_word(blk_data_i, i);
      end else if (rnd_hs) begin
        if (j_end) begin
          j_q <= '0;
        end else begin
          j_q <= j_q + 6'd1;
          for (int i = 0; i < 15; i++) win_q[i] <= win_q[i+1];
          win_q[15] <= w_new;
        end
      end
    end
  end

  assign t_base               = (j_q < 6'd16) ? T_LO : T_HI;
  assign tj_o                 = rotl(t_base, j_q[4:0]);
  assign wj_o                 = win_q[0];
  assign wjj_o                = win_q[0] ^ win_q[4];
  assign rnd_idx_o            = j_q;
  assign rnd_last_o           = (state_q == RUN) && j_end;
  assign cmprss_round_sm_16_o = (j_q < 6'd16);

endmodule

// File: tb/tb_sm3_expnd_core.sv
// Directed bench for sm3_expnd_core: "abc" block streaming, backpressure,
// mid-block reset, a second block and the byte-swapped load variant.
module tb_sm3_expnd_core;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   blk_vld;
  logic [1:0]   blk_rdy;
  logic [511:0] blk_data [2];
  logic [1:0]   rnd_vld;
  logic [1:0]   rnd_rdy;
  logic [5:0]   rnd_idx [2];
  logic [1:0]   rnd_last;
  logic [1:0]   sm16;
  logic [31:0]  tj [2];
  logic [31:0]  wj [2];
  logic [31:0]  wjj [2];

  int           sel;
  logic         m_brdy, m_vld, m_last, m_sm16;
  logic [5:0]   m_idx;
  logic [31:0]  m_tj, m_wj, m_wjj;

  int           n_chk = 0;
  int           n_pass = 0;
  int           hs_cnt = 0;
  logic [31:0]  mw [68];
  logic [31:0]  rec_wj [64];
  logic [31:0]  rec_wjj [64];
  logic [31:0]  rec_tj [64];

  localparam logic [511:0] ABC =
    {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam logic [511:0] ABC_SW =
    {32'h80636261, {14{32'h0}}, 32'h18000000};

  always #5 clk = ~clk;

  sm3_expnd_core #(.BYTE_SWAP(1'b0)) u_dut0 (
    .clk(clk), .rst(rst),
    .blk_vld_i(blk_vld[0]), .blk_rdy_o(blk_rdy[0]),
    .blk_data_i(blk_data[0]),
    .rnd_vld_o(rnd_vld[0]), .rnd_rdy_i(rnd_rdy[0]),
    .rnd_idx_o(rnd_idx[0]), .rnd_last_o(rnd_last[0]),
    .cmprss_round_sm_16_o(sm16[0]),
    .tj_o(tj[0]), .wj_o(wj[0]), .wjj_o(wjj[0])
  );

  sm3_expnd_core #(.BYTE_SWAP(1'b1)) u_dut1 (
    .clk(clk), .rst(rst),
    .blk_vld_i(blk_vld[1]), .blk_rdy_o(blk_rdy[1]),
    .blk_data_i(blk_data[1]),
    .rnd_vld_o(rnd_vld[1]), .rnd_rdy_i(rnd_rdy[1]),
    .rnd_idx_o(rnd_idx[1]), .rnd_last_o(rnd_last[1]),
    .cmprss_round_sm_16_o(sm16[1]),
    .tj_o(tj[1]), .wj_o(wj[1]), .wjj_o(wjj[1])
  );

  always_comb begin
    m_brdy = blk_rdy[sel];
    m_vld  = rnd_vld[sel];
    m_last = rnd_last[sel];
    m_sm16 = sm16[sel];
    m_idx  = rnd_idx[sel];
    m_tj   = tj[sel];
    m_wj   = wj[sel];
    m_wjj  = wjj[sel];
  end

  always @(posedge clk)
    if (m_vld && rnd_rdy[sel]) hs_cnt <= hs_cnt + 1;

  task automatic chk(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    int s;
    s = n % 32;
    if (s == 0) return x;
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] tj_ref(input int k);
    return rl((k < 16) ? 32'h79cc4519 : 32'h7a879d8a, k);
  endfunction

  task automatic build(input logic [511:0] b);
    logic [31:0] x;
    for (int i = 0; i < 16; i++) mw[i] = b[511-32*i -: 32];
    for (int i = 16; i < 68; i++) begin
      x = mw[i-16] ^ mw[i-9] ^ rl(mw[i-3], 15);
      x = x ^ rl(x, 15) ^ rl(x, 23);
      mw[i] = x ^ rl(mw[i-13], 7) ^ mw[i-6];
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rst"},
        {m_brdy, m_vld, m_last, m_sm16, m_idx, m_tj, m_wj, m_wjj},
        {1'b1, 1'b0, 1'b0, 1'b1, 6'd0, 32'h79cc4519, 32'h0, 32'h0});
  endtask

  // Streams one block; model is built from the unswapped block.
  task automatic run_block(
    input int           s,
    input logic [511:0] blk,
    input logic [511:0] mdl,
    input bit           stall,
    input int           abort_at
  );
    int k;
    int cyc;
    int hs0;
    build(mdl);
    sel = s;
    @(posedge clk); #1;
    blk_vld[s]  = 1'b1;
    blk_data[s] = blk;
    @(negedge clk);
    chk("blk_rdy_idle", m_brdy, 1'b1);
    hs0 = hs_cnt;
    @(posedge clk); #1;
    // During RUN the source may keep vld up with junk; it must be ignored.
    blk_vld[s]  = stall;
    blk_data[s] = {16{$urandom()}};
    k   = 0;
    cyc = 0;
    while (k < 64 && cyc < 2000) begin
      rnd_rdy[s] = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      cyc++;
      chk($sformatf("rnd%0d", k),
          {m_brdy, m_vld, m_last, m_sm16, m_idx, m_tj, m_wj, m_wjj},
          {1'b0, 1'b1, k == 63, k < 16, 6'(k), tj_ref(k), mw[k],
           mw[k] ^ mw[k+4]});
      rec_wj[k]  = m_wj;
      rec_wjj[k] = m_wjj;
      rec_tj[k]  = m_tj;
      if (k == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rnd_rdy[s] = 1'b0;
        blk_vld[s] = 1'b0;
        @(negedge clk);
        chk_reset("abort");
        @(negedge clk);
        chk("abort_hold", {m_vld, m_brdy}, 2'b01);
        return;
      end
      if (m_vld && rnd_rdy[s]) k++;
      @(posedge clk); #1;
    end
    blk_vld[s] = 1'b0;
    rnd_rdy[s] = 1'b0;
    chk("rounds_seen", k, 64);
    @(negedge clk);
    chk("post_last", {m_brdy, m_vld, m_last}, 3'b100);
    @(negedge clk);
    @(negedge clk);
    chk("hs_count", hs_cnt - hs0, 64);
    chk("stay_idle", {m_brdy, m_vld}, 2'b10);
  endtask

  initial begin
    logic [511:0] blk2;
    sel      = 0;
    rst      = 1'b1;
    blk_vld  = '0;
    rnd_rdy  = '0;
    blk_data[0] = '0;
    blk_data[1] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_reset("init");

    run_block(0, ABC, ABC, 1'b0, -1);
    chk("j0_wj",   rec_wj[0],   32'h61626380);
    chk("j0_wjj",  rec_wjj[0],  32'h61626380);
    chk("j0_tj",   rec_tj[0],   32'h79cc4519);
    chk("j1_tj",   rec_tj[1],   32'hF3988A32);
    chk("j12_wjj", rec_wjj[12], 32'h9092E200);
    chk("j16_wj",  rec_wj[16],  32'h9092E200);
    chk("j16_tj",  rec_tj[16],  32'h9D8A7A87);
    chk("j17_wj",  rec_wj[17],  32'h00000000);
    chk("j33_tj",  rec_tj[33],  32'hF50F3B14);

    run_block(0, ABC, ABC, 1'b1, -1);
    run_block(0, ABC, ABC, 1'b0, 20);

    for (int i = 0; i < 16; i++)
      blk2[511-32*i -: 32] = 32'h12345678 ^ (32'h01010101 * i);
    run_block(0, blk2, blk2, 1'b0, -1);
    chk("blk2_w0", rec_wj[0], 32'h12345678);

    run_block(1, ABC_SW, ABC, 1'b0, -1);
    chk("sw_j0_wj", rec_wj[0], 32'h61626380);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
